sd_tx_fill: RTL

//  Wishbone master fetch engine that sits directly upstream of the SD TX FIFO.

---
 rtl/sd_tx_fill.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_tx_fill.sv
// ---------------------------------------------------------------------------
// sd_tx_fill
//
// Wishbone master fetch engine feeding the SD TX FIFO write port. A transfer
// reads word_cnt 32-bit words starting at start_adr using incrementing
// Wishbone bursts of at most BURST_LEN beats. A burst is only launched once
// the FIFO has room for every beat of it, so an acked word never meets a
// full FIFO. Every acked word goes straight into the FIFO on the same cycle.
//
// Build option:
//   SD_TX_FILL_BSWAP_EN  defined   -> fifo_d is m_wb_dat_i byte-reversed
//                                     (little-endian bus to SD MSB-first)
//                        undefined -> fifo_d is m_wb_dat_i unchanged
//
// Ports:
//   wclk        clock (Wishbone master and FIFO write side)
//   rst         asynchronous active-high reset
//   start       1-cycle pulse, begins a transfer when idle
//   abort       terminates any transfer in progress at the next edge
//   start_adr   byte address of first word (bits [1:0] forced to 0)
//   word_cnt    number of 32-bit words to fetch
//   busy        high whenever a transfer is in progress
//   done        1-cycle pulse after the last word has been pushed
//   err         1-cycle pulse after a Wishbone error ended a transfer
//   m_wb_*      Wishbone B3 master (read only, linear incrementing bursts)
//   fifo_d      FIFO write data
//   fifo_wr     FIFO write strobe
//   fifo_full   FIFO full flag (diagnostic only)
//   fifo_level  FIFO occupancy in words
// ---------------------------------------------------------------------------
module sd_tx_fill #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      start_adr,
  input  logic [LEN_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      m_wb_adr_o,
  output logic [3:0]       m_wb_sel_o,
  output logic             m_wb_we_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  output logic [2:0]       m_wb_cti_o,
  output logic [1:0]       m_wb_bte_o,
  input  logic [31:0]      m_wb_dat_i,
  input  logic             m_wb_ack_i,
  input  logic             m_wb_err_i,
  output logic [31:0]      fifo_d,
  output logic             fifo_wr,
  input  logic             fifo_full,
  input  logic [5:0]       fifo_level
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      adr_reg, adr_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [4:0]       beats_left_reg, beats_left_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [4:0]       burst_beats;
  logic [6:0]       level_ext;
  logic [6:0]       fifo_space;
  logic             space_ok;
  logic             beat_ack;
  logic             beat_err;

  // Size of the next burst: a full BURST_LEN unless fewer words remain.
  always_comb begin
    burst_beats = 5'(BURST_LEN);
    if (remaining_reg < LEN_W'(BURST_LEN)) begin
      burst_beats = remaining_reg[4:0];
    end
  end

  // Free FIFO space. A level at or above the depth (should the level
  // counter ever overshoot) is treated as no space at all rather than
  // letting the subtraction wrap to a huge value.
  assign level_ext = {1'b0, fifo_level};

  always_comb begin
    fifo_space = 7'd0;
    if (level_ext < 7'(FIFO_DEPTH)) begin
      fifo_space = 7'(FIFO_DEPTH) - level_ext;
    end
  end

  assign space_ok = (fifo_space >= {2'b00, burst_beats});

  // An error beat never counts as data, even if the slave also raised ack.
  assign beat_ack = (state_reg == BURST) & m_wb_ack_i & ~m_wb_err_i;
  assign beat_err = (state_reg == BURST) & m_wb_err_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      adr_reg        <= 32'd0;
      remaining_reg  <= '0;
      beats_left_reg <= 5'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      adr_reg        <= adr_next;
      remaining_reg  <= remaining_next;
      beats_left_reg <= beats_left_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    adr_next        = adr_reg;
    remaining_next  = remaining_reg;
    beats_left_next = beats_left_reg;
    done_next       = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort takes priority over a coincident start
        if (start && !abort) begin
          adr_next       = {start_adr[31:2], 2'b00};
          remaining_next = word_cnt;
          if (word_cnt == '0) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_SPACE;
          end
        end
      end

      WAIT_SPACE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (space_ok) begin
          beats_left_next = burst_beats;
          state_next      = BURST;
        end
      end

      BURST: begin
        if (beat_err) begin
          // Transfer abandoned; remaining keeps the unfetched count.
          err_next   = !abort;
          state_next = IDLE;
        end else if (beat_ack) begin
          // The acked word is pushed to the FIFO even when abort is high,
          // so the counters track it as well.
          adr_next        = adr_reg + 32'd4;
          remaining_next  = remaining_reg - LEN_W'(1);
          beats_left_next = beats_left_reg - 5'd1;
          if (abort) begin
            state_next = IDLE;
          end else if (beats_left_reg == 5'd1) begin
            if (remaining_reg == LEN_W'(1)) begin
              state_next = DONE;
            end else begin
              state_next = WAIT_SPACE;
            end
          end
        end else if (abort) begin
          state_next = IDLE;
        end
      end

      DONE: begin
        state_next = IDLE;
        done_next  = !abort;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus outputs. cyc/stb are decoded from the state so that the async reset
  // clears them immediately.
  // -------------------------------------------------------------------------
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
  assign m_wb_adr_o = adr_reg;
  assign m_wb_sel_o = 4'hF;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_cyc_o = (state_reg == BURST);
  assign m_wb_stb_o = m_wb_cyc_o;
  assign m_wb_bte_o = 2'b00;

  always_comb begin
    m_wb_cti_o = 3'b000;
    if (m_wb_cyc_o) begin
      m_wb_cti_o = (beats_left_reg == 5'd1) ? 3'b111 : 3'b010;
    end
  end

  // Zero-latency FIFO push of every acked, error-free beat.
  assign fifo_wr = m_wb_ack_i & m_wb_cyc_o & ~m_wb_err_i;

`ifdef SD_TX_FILL_BSWAP_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bswap
      assign fifo_d[8*gi +: 8] = m_wb_dat_i[8*(3-gi) +: 8];
    end
  endgenerate
`else
  assign fifo_d = m_wb_dat_i;
`endif

  // fifo_full is informational only: space is guaranteed before a burst
  // starts. The low address bits are always dropped.
  logic unused_ok;
  assign unused_ok = &{1'b0, fifo_full, start_adr[1:0]};

endmodule
